// File: rtl/uart_tx_frame_if.sv
// Parallel-side request and serial-side status of the UART frame transmitter.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] i_par_data;
  logic                  i_data_valid;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic                  o_tx_out;
  logic                  o_busy;

  // Requester side: supplies the word and frame options, watches the line.
  modport master (
    output i_par_data,
    output i_data_valid,
    output i_par_en,
    output i_par_typ,
    input  o_tx_out,
    input  o_busy
  );

  // Transmitter side.
  modport slave (
    input  i_par_data,
    input  i_data_valid,
    input  i_par_en,
    input  i_par_typ,
    output o_tx_out,
    output o_busy
  );

endinterface

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Runs on the bit clock, so every state step is exactly one bit period on the line.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic             i_clk,
  input logic             i_rst_n,
  uart_tx_frame_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;

  // State, line and frame-latch registers; synchronous active-low reset aborts any frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Next-state logic; tx_d is the bit that will be on the line during the next bit period.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.i_data_valid) begin
          // Everything the frame needs is captured here so later input changes are ignored.
          shift_d   = bus.i_par_data;
          par_en_d  = bus.i_par_en;
          par_bit_d = (^bus.i_par_data) ^ bus.i_par_typ;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = StStart;
        end
      end
      StStart: begin
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
        state_d = StData;
      end
      StData: begin
        // cnt_q indexes the data bit currently on the line.
        if (cnt_q == CntMax) begin
          cnt_d = '0;
          if (par_en_q) begin
            tx_d    = par_bit_q;
            state_d = StParity;
          end else begin
            tx_d    = 1'b1;
            state_d = StStop;
          end
        end else begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        tx_d    = 1'b1;
        state_d = StStop;
      end
      StStop: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign bus.o_tx_out = tx_q;
  assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed cases plus random frames against a
// bit-list model of the frame built from the word and its options.
module tb_uart_tx_frame;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  bit exp_q[$];

  uart_tx_frame_if #(.DATA_WIDTH(W)) bus ();

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected line contents, one entry per bit period, start bit first.
  task automatic build_frame(input logic [W-1:0] d, input logic en, input logic typ);
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < int'(W); i++) exp_q.push_back(d[i]);
    // Even parity makes the total count of ones even; odd parity makes it odd.
    if (en) exp_q.push_back(($countones(d) % 2 == 1) ? ~typ : typ);
    exp_q.push_back(1'b1);
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge after busy drops.
  task automatic play_frame(input logic [W-1:0] d, input logic en, input logic typ,
                            input bit scramble, input bit keep_valid);
    build_frame(d, en, typ);
    bus.i_par_data   = d;
    bus.i_par_en     = en;
    bus.i_par_typ    = typ;
    bus.i_data_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (!keep_valid) bus.i_data_valid = 1'b0;
      check($sformatf("tx d=%02h en=%0d typ=%0d bit%0d", d, en, typ, i), 32'(bus.o_tx_out),
            32'(exp_q[i]));
      check($sformatf("busy d=%02h bit%0d", d, i), 32'(bus.o_busy), 32'd1);
      if (scramble) begin
        bus.i_par_data = W'($urandom);
        bus.i_par_typ  = 1'($urandom);
        bus.i_par_en   = 1'($urandom);
      end
    end
    @(negedge clk);
    check($sformatf("gap busy d=%02h", d), 32'(bus.o_busy), 32'd0);
    check($sformatf("gap tx d=%02h", d), 32'(bus.o_tx_out), 32'd1);
  endtask

  initial begin
    logic [W-1:0] rd;
    n_vec = 0;
    n_err = 0;

    // Reset held with a pending request: nothing may start.
    rst_n            = 1'b0;
    bus.i_data_valid = 1'b1;
    bus.i_par_data   = 8'hA5;
    bus.i_par_en     = 1'b0;
    bus.i_par_typ    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset tx", 32'(bus.o_tx_out), 32'd1);
      check("reset busy", 32'(bus.o_busy), 32'd0);
    end
    rst_n            = 1'b1;
    bus.i_data_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post-reset tx", 32'(bus.o_tx_out), 32'd1);
      check("post-reset busy", 32'(bus.o_busy), 32'd0);
    end

    // Directed frames.
    play_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    play_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    play_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    play_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    play_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);

    // Back-to-back with valid held: exactly one idle cycle between frames.
    play_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    play_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while data bit 4 of 0xFF is on the line.
    bus.i_par_data   = 8'hFF;
    bus.i_par_en     = 1'b1;
    bus.i_par_typ    = 1'b0;
    bus.i_data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_data_valid = 1'b0;
    check("abort start bit", 32'(bus.o_tx_out), 32'd0);
    repeat (5) @(negedge clk);
    check("abort data bit4", 32'(bus.o_tx_out), 32'd1);
    check("abort busy before", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort tx", 32'(bus.o_tx_out), 32'd1);
    check("abort busy", 32'(bus.o_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort idle busy", 32'(bus.o_busy), 32'd0);
    play_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random frames with random options, mid-frame input churn and back-to-back chaining.
    for (int n = 0; n < 40; n++) begin
      rd = W'($urandom);
      play_frame(rd, 1'($urandom), 1'($urandom), bit'($urandom), bit'($urandom));
    end
    bus.i_data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("final idle tx", 32'(bus.o_tx_out), 32'd1);
    check("final idle busy", 32'(bus.o_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
